regfile_controller: RTL
=======================

REGFILE_CONTROLLER -- requirements
Module: regfile_controller

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  controller accepts a command this cycle.
REQ-006 cmd_op  in  3  opcode: 000 NOP, 001 READ, 010 WRITE, 011 WRITEU, 100 INC, 101 DEC, 110 MOVE, 111 SWAP.
REQ-007 cmd_rd  in  6  destination/target register id.
REQ-008 cmd_rs  in  6  source register id (MOVE, SWAP only).
REQ-009 cmd_data  in  16  write data (WRITE, WRITEU only).
REQ-010 rsp_valid  out  1  one-cycle pulse; rsp_data valid.
REQ-011 rsp_data  out  16  READ result.
REQ-012 rf_din  out  16; rf_read, rf_write, rf_writeu, rf_inc, rf_dec  out  1 each; rf_id  out  6 -- register file control.
REQ-013 rf_dout  in  16  register file read data, valid combinationally while rf_read=1.
REQ-014 cmd_count  out  16  completed-command counter.

Function
REQ-015 States SHALL be IDLE, EXEC, RD_A, RD_B, WR_A, WR_B; cmd_ready=1 only in IDLE.
REQ-016 Handshake: command accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op/cmd_rd/cmd_rs/cmd_data latched on that edge; inputs ignored while cmd_ready=0.
REQ-017 Transitions from IDLE on accept: NOP/WRITE/WRITEU/INC/DEC -> EXEC; READ/MOVE/SWAP -> RD_A.
REQ-018 EXEC: exactly one strobe per op (WRITE->rf_write, WRITEU->rf_writeu, INC->rf_inc, DEC->rf_dec, NOP->none), rf_id=rd, rf_din=data (0 when unused); next state IDLE.
REQ-019 READ: RD_A drives rf_read=1, rf_id=rd; rf_dout captured into rsp_data at end of RD_A; rsp_valid=1 for exactly the following cycle; next state IDLE.
REQ-020 MOVE: RD_A reads rs into tmp_a; WR_A drives rf_write=1, rf_id=rd, rf_din=tmp_a; then IDLE.
REQ-021 SWAP: RD_A reads rs -> tmp_a; RD_B reads rd -> tmp_b; WR_A writes rd<=tmp_a; WR_B writes rs<=tmp_b; then IDLE.
REQ-022 SWAP/MOVE with rs==rd SHALL execute the full sequence unchanged (net register value unchanged).
REQ-023 Latency (accept edge to cmd_ready high): 2 cycles NOP/WRITE/WRITEU/INC/DEC/READ, 3 cycles MOVE, 5 cycles SWAP; rsp_valid 2 cycles after READ accept edge.
REQ-024 At most one of rf_read/rf_write/rf_writeu/rf_inc/rf_dec SHALL be high in any cycle; outside strobe states all strobes, rf_id and rf_din are 0.
REQ-025 rf_id passed through without range check (all 64 values legal).
REQ-026 rsp_data SHALL hold its last value until the next READ capture.
REQ-027 cmd_count SHALL increment by 1 on the edge leaving the last state of each command (including NOP), wrapping 0xFFFF -> 0x0000.

Reset
REQ-028 On a clk edge with rst_n=0: state IDLE, tmp_a=tmp_b=0, rsp_data=0, rsp_valid=0, cmd_count=0; all rf_* outputs 0.
REQ-029 cmd_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after rst_n returns high.
REQ-030 Reset mid-command SHALL abort it: no further strobes after the reset edge, no rsp_valid, command not counted.

Verification
REQ-031 Reset: rst_n low 2 cycles, cmd_valid=1 -> no accept, all outputs 0; cmd_ready=1 first cycle after release.
REQ-032 WRITE rd=1 data=0x0F0F, then READ rd=1 (bench RF model) -> one rf_write cycle with rf_id=1, rf_din=0x0F0F; rsp_valid pulse 2 cycles after READ accept, rsp_data=0x0F0F; cmd_count=2.
REQ-033 WRITEU rd=0 data=0x00F3 -> single rf_writeu cycle, rf_id=0, rf_din=0x00F3, no other strobe.
REQ-034 R0=0xF30F; INC rd=0, READ, DEC rd=0, READ -> rsp_data 0xF310 then 0xF30F; each INC/DEC exactly one strobe cycle.
REQ-035 R2=0x1234, R3=0xABCD; SWAP rs=2 rd=3 -> strobe sequence read(2), read(3), write(3,0x1234), write(2,0xABCD); cmd_ready low 4 cycles; back-to-back cmd_valid held high accepted only in IDLE.
REQ-036 Reset asserted during RD_B of SWAP -> no rf_write strobes, R2/R3 unchanged, cmd_count=0; separately preload cmd_count to 0xFFFF via commands and issue NOP -> cmd_count=0x0000.

Source files
------------

// File: rtl/regfile_controller.sv
// Purpose : sequences register-file commands (NOP/READ/WRITE/WRITEU/INC/DEC/MOVE/SWAP) into rf_* strobes.
// Latency : one busy state for NOP/WRITE/WRITEU/INC/DEC/READ, two for MOVE, four for SWAP; READ rsp one cycle after its read state.
// Backpr. : cmd_ready high only in IDLE (and out of reset); cmd_* ignored while busy.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_rd/cmd_rs/cmd_data latched on accept
//   rsp_valid/rsp_data         one-cycle READ response pulse; rsp_data holds until next READ
//   rf_read/write/writeu/inc/dec, rf_id, rf_din, rf_dout   register-file control and read data
//   cmd_count                  completed-command counter (wraps)
module regfile_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [5:0]  cmd_rd,
    input  logic [5:0]  cmd_rs,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rf_din,
    output logic        rf_read,
    output logic        rf_write,
    output logic        rf_writeu,
    output logic        rf_inc,
    output logic        rf_dec,
    output logic [5:0]  rf_id,
    input  logic [15:0] rf_dout,
    output logic [15:0] cmd_count
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_READ   = 3'b001;
    localparam logic [2:0] OP_WRITE  = 3'b010;
    localparam logic [2:0] OP_WRITEU = 3'b011;
    localparam logic [2:0] OP_INC    = 3'b100;
    localparam logic [2:0] OP_DEC    = 3'b101;
    localparam logic [2:0] OP_MOVE   = 3'b110;
    localparam logic [2:0] OP_SWAP   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_RD_A = 3'd2,
        S_RD_B = 3'd3,
        S_WR_A = 3'd4,
        S_WR_B = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [5:0]  rd_q;
    logic [5:0]  rs_q;
    logic [15:0] data_q;
    logic [15:0] tmp_a;
    logic [15:0] tmp_b;
    logic        accept;
    logic        last;      // final state of the current command; drives cmd_count

    // cmd_ready is forced low while reset is held so nothing can be accepted
    // on the reset edge itself.
    assign cmd_ready = rst_n && (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        rf_read   = 1'b0;
        rf_write  = 1'b0;
        rf_writeu = 1'b0;
        rf_inc    = 1'b0;
        rf_dec    = 1'b0;
        rf_id     = 6'd0;
        rf_din    = 16'd0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_READ || cmd_op == OP_MOVE || cmd_op == OP_SWAP)
                        state_nxt = S_RD_A;
                    else
                        state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                rf_id = rd_q;
                case (op_q)
                    OP_WRITE: begin
                        rf_write = 1'b1;
                        rf_din   = data_q;
                    end
                    OP_WRITEU: begin
                        rf_writeu = 1'b1;
                        rf_din    = data_q;
                    end
                    OP_INC:  rf_inc = 1'b1;
                    OP_DEC:  rf_dec = 1'b1;
                    default: ;  // NOP: no strobe
                endcase
                last      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RD_A: begin
                // READ targets rd; MOVE/SWAP fetch the source first.
                rf_read = 1'b1;
                rf_id   = (op_q == OP_READ) ? rd_q : rs_q;
                if (op_q == OP_READ) begin
                    last      = 1'b1;
                    state_nxt = S_IDLE;
                end else if (op_q == OP_MOVE) begin
                    state_nxt = S_WR_A;
                end else begin
                    state_nxt = S_RD_B;
                end
            end
            S_RD_B: begin
                rf_read   = 1'b1;
                rf_id     = rd_q;
                state_nxt = S_WR_A;
            end
            S_WR_A: begin
                rf_write = 1'b1;
                rf_id    = rd_q;
                rf_din   = tmp_a;
                if (op_q == OP_SWAP) begin
                    state_nxt = S_WR_B;
                end else begin
                    last      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WR_B: begin
                rf_write  = 1'b1;
                rf_id     = rs_q;
                rf_din    = tmp_b;
                last      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            rd_q      <= 6'd0;
            rs_q      <= 6'd0;
            data_q    <= 16'd0;
            tmp_a     <= 16'd0;
            tmp_b     <= 16'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
            cmd_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                rd_q   <= cmd_rd;
                rs_q   <= cmd_rs;
                data_q <= cmd_data;
            end
            if (state == S_RD_A) begin
                if (op_q == OP_READ)
                    rsp_data <= rf_dout;
                else
                    tmp_a <= rf_dout;
            end
            if (state == S_RD_B)
                tmp_b <= rf_dout;
            rsp_valid <= (state == S_RD_A) && (op_q == OP_READ);
            if (last)
                cmd_count <= cmd_count + 16'd1;
        end
    end

endmodule
